dot_accum_relu: RTL

- Downstream stage of the per-channel dot-product unit.
- Consumes the unit's `valid`/`q` result stream and sums NUM_PHASE successive partial dot products into one output-channel value.
- Adds a constant bias, applies ReLU and positive saturation, then buffers results in a small FIFO with a valid/ready handshake toward the feature-map writer.

---
 rtl/dot_accum_relu.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dot_accum_relu.sv
// dot_accum_relu: sums NUM_PHASE successive partial dot products into one
// output-channel value, adds BIAS, applies ReLU with positive saturation and
// queues the result in a small FIFO toward the feature-map writer.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   level valid; only its rising edge captures in_data
//   in_data    signed partial dot product (DATA_LEN bits)
//   clear      synchronous flush of accumulator, stage register and FIFO
//   out_ready  consumer accepts out_data this cycle
//   out_valid  FIFO non-empty
//   out_data   FIFO head (0 while empty)
//   busy       accumulation in progress or stage register full
//   overflow   sticky: a result was dropped because the FIFO was full
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module dot_accum_relu #(
  parameter int                          NUM_PHASE  = 4,
  parameter logic signed [`DATA_LEN-1:0] BIAS       = '0,
  parameter int                          FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [`DATA_LEN-1:0] in_data,
  input  logic                 clear,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [`DATA_LEN-1:0] out_data,
  output logic                 busy,
  output logic                 overflow
);

  localparam int DL = `DATA_LEN;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] LAST_PHASE = 4'(NUM_PHASE - 1);
  localparam logic signed [DL+3:0] SAT_MAX = (DL+4)'((2 ** (DL - 1)) - 1);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;

  state_t                 state_reg, state_next;
  logic                   prev_valid_reg;
  logic [3:0]             phase_reg;
  logic signed [DL+3:0]   acc_reg;
  logic signed [DL+3:0]   stage_reg;
  logic [DL-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]            count_reg;
  logic                   overflow_reg;

  logic                   capture, last_phase, stage_full;
  logic signed [DL+3:0]   in_ext, bias_ext, acc_sum;
  logic [DL-1:0]          wr_data;
  logic                   full, pop, push_ok, drop;

  // Only the rising edge of the level valid counts as a new partial sum.
  assign capture    = in_valid & ~prev_valid_reg;
  assign last_phase = (phase_reg == LAST_PHASE);
  assign in_ext     = {{4{in_data[DL-1]}}, in_data};
  assign bias_ext   = {{4{BIAS[DL-1]}}, BIAS};
  // Phase 0 starts a fresh group regardless of what acc_reg still holds.
  assign acc_sum    = ((phase_reg == 4'd0) ? '0 : acc_reg) + in_ext;
  assign stage_full = (state_reg == EMIT);

  // Next-state logic. EMIT lasts exactly one cycle (the FIFO push); a capture
  // landing in that cycle already belongs to the following group.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (capture) state_next = last_phase ? EMIT : ACC;
      ACC:  if (capture && last_phase) state_next = EMIT;
      EMIT: begin
        if (capture) state_next = last_phase ? EMIT : ACC;
        else         state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      prev_valid_reg <= 1'b0;
      phase_reg      <= 4'd0;
      acc_reg        <= '0;
      stage_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (clear) begin
        prev_valid_reg <= 1'b0;
        phase_reg      <= 4'd0;
        acc_reg        <= '0;
        stage_reg      <= '0;
      end else begin
        prev_valid_reg <= in_valid;
        if (capture) begin
          acc_reg   <= acc_sum;
          phase_reg <= last_phase ? 4'd0 : phase_reg + 4'd1;
          if (last_phase) stage_reg <= acc_sum + bias_ext;
        end
      end
    end
  end

  // ReLU plus positive saturation on the way into the FIFO.
  always_comb begin
    wr_data = stage_reg[DL-1:0];
    if (stage_reg < 0)             wr_data = '0;
    else if (stage_reg > SAT_MAX)  wr_data = SAT_MAX[DL-1:0];
  end

  assign full    = (count_reg == FULL_COUNT);
  assign pop     = out_valid & out_ready;
  // A push into a full FIFO still succeeds when the head leaves this edge.
  assign push_ok = stage_full & (~full | pop);
  assign drop    = stage_full & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (clear) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (drop) overflow_reg <= 1'b1;
    end
  end

  assign out_valid = (count_reg != '0);
  assign out_data  = out_valid ? mem[rd_ptr_reg] : '0;
  assign busy      = (phase_reg != 4'd0) | stage_full;
  assign overflow  = overflow_reg;

endmodule
